multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM that drives the ALU op-select input and consumes its Zero flag.

---
 rtl/cpu_ctrl_pkg.sv | 55 +++++
 rtl/ctrl_main_decoder.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared constants and types for the multi-cycle control unit:
//   - opcode / funct encodings of the supported instruction subset
//   - ALU operation codes and datapath mux-select encodings
//   - state_t (controller FSM state) and iclass_t (decoded instruction class)
// No ports; imported by ctrl_main_decoder and multicycle_ctrl.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_RS   = 1'b1;
    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // S_HALT is only reachable when the illegal-instruction trap is built in.
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_ADD,
        CL_SUB,
        CL_ADDI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BNE,
        CL_J,
        CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/ctrl_main_decoder.sv
// ctrl_main_decoder
// Purely combinational instruction classifier.
// Ports:
//   opcode_i  in  OPW  instruction opcode field
//   funct_i   in  OPW  function field, meaningful only for R-type
//   iclass_o  out      decoded instruction class (CL_ILLEGAL if undecodable)
//   legal_o   out 1    1 when the opcode/funct pair is supported
module ctrl_main_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode_i,
    input  logic [OPW-1:0] funct_i,
    output iclass_t        iclass_o,
    output logic           legal_o
);

    always_comb begin
        iclass_o = CL_ILLEGAL;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == F_ADD) begin
                    iclass_o = CL_ADD;
                end else if (funct_i == F_SUB) begin
                    iclass_o = CL_SUB;
                end
            end
            OP_J:    iclass_o = CL_J;
            OP_BEQ:  iclass_o = CL_BEQ;
            OP_BNE:  iclass_o = CL_BNE;
            OP_ADDI: iclass_o = CL_ADDI;
            OP_LW:   iclass_o = CL_LW;
            OP_SW:   iclass_o = CL_SW;
            default: iclass_o = CL_ILLEGAL;
        endcase
    end

    assign legal_o = (iclass_o != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) for addi, add, sub, lw, sw, beq,
// bne and j. Drives ALU op-select, datapath mux selects and strobes, consumes
// the ALU Zero flag and a memory-ready handshake, and counts retired
// instructions.
// Build option: ILLEGAL_TRAP_EN
//   defined   - an undecodable instruction halts the FSM in S_HALT with
//               illegal held high until reset.
//   undefined - an undecodable instruction retires as a NOP from S_ID and
//               illegal pulses for that one cycle.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   opcode, funct          instruction fields from the IR
//   zero                   ALU Zero flag (sampled in EX)
//   mem_ready              memory access completes this cycle
//   alu_op                 000 add, 001 sub
//   alu_src_a, alu_src_b   ALU operand mux selects
//   pc_write, pc_src       PC load strobe and source select
//   ir_write               IR load strobe
//   mem_read, mem_write    memory requests
//   reg_write, reg_dst,
//   mem_to_reg             register-file write strobe and muxes
//   illegal                undecodable instruction indicator
//   retired                completed-instruction count (wraps)
//   state_dbg              current FSM state, for observation only
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic [OPW-1:0]  funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [2:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            ir_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            illegal,
    output logic [CNTW-1:0] retired,
    output state_t          state_dbg
);

    state_t          state_q, state_d;
    logic [CNTW-1:0] retired_q, retired_d;
    logic            retire;
    iclass_t         iclass;
    logic            legal;

    ctrl_main_decoder #(.OPW(OPW)) u_dec (
        .opcode_i (opcode),
        .funct_i  (funct),
        .iclass_o (iclass),
        .legal_o  (legal)
    );

    // Next state and retire strobe.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IF: begin
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                if (iclass == CL_J) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_IF;
                    retire  = 1'b1;
`endif
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (iclass)
                    CL_ADD, CL_SUB, CL_ADDI: state_d = S_WB;
                    CL_LW, CL_SW:            state_d = S_MEM;
                    CL_BEQ, CL_BNE: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    default:                 state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (iclass == CL_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_IF;
                        retire  = (iclass == CL_SW);
                    end
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    assign retired_d = retired_q + {{(CNTW-1){1'b0}}, retire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Output decode from state + instruction class. Everything is forced to 0
    // while rst is high, so an in-flight access is dropped at once rather than
    // at the next edge.
    always_comb begin
        alu_op     = ALU_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RT;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID: begin
                    if (iclass == CL_J) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                    end
`ifndef ILLEGAL_TRAP_EN
                    illegal = !legal;
`endif
                end
                S_EX: begin
                    alu_src_a = SRC_A_RS;
                    case (iclass)
                        CL_SUB: alu_op = ALU_SUB;
                        CL_ADDI, CL_LW, CL_SW: alu_src_b = SRC_B_IMM;
                        CL_BEQ, CL_BNE: begin
                            alu_op   = ALU_SUB;
                            pc_src   = PC_SRC_BRANCH;
                            // Mealy: the branch decision uses this cycle's Zero.
                            pc_write = (iclass == CL_BEQ) ? zero : !zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_read  = (iclass == CL_LW);
                    mem_write = (iclass == CL_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (iclass == CL_ADD) || (iclass == CL_SUB);
                    mem_to_reg = (iclass == CL_LW);
                end
                S_HALT:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Instruction-level reference bench for multicycle_ctrl. Each instruction is
// walked phase by phase (fetch with optional waits, decode, execute, memory
// with optional waits, writeback); the expected control word for each cycle
// comes from the instruction's behaviour, and the retired count from a
// wrapping counter kept here. Build with or without +define+ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int CNTW = 6;

    localparam int K_ADD  = 0;
    localparam int K_SUB  = 1;
    localparam int K_ADDI = 2;
    localparam int K_LW   = 3;
    localparam int K_SW   = 4;
    localparam int K_BEQ  = 5;
    localparam int K_BNE  = 6;
    localparam int K_J    = 7;
    localparam int K_ILL  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]      opcode = '0;
    logic [5:0]      funct  = '0;
    logic            zero   = 1'b0;
    logic            mem_ready = 1'b0;
    logic [2:0]      alu_op;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic            pc_write;
    logic [1:0]      pc_src;
    logic            ir_write;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            illegal;
    logic [CNTW-1:0] retired;
    state_t          state_dbg;

    multicycle_ctrl #(.OPW(6), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    logic [15:0] got_ctrl;
    assign got_ctrl = {alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                       mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal};

    // ---------------- scoreboard ----------------
    int              checks = 0;
    int              errors = 0;
    logic [CNTW-1:0] model_cnt = '0;
    logic [CNTW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic a, input logic [1:0] b,
                                       input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic rd, input logic m2r, input logic ill);
        return {op, a, b, pcw, pcs, irw, mr, mw, rw, rd, m2r, ill};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h20) ? K_ADD : (fn == 6'h22) ? K_SUB : K_ILL;
        if (op == 6'h02) return K_J;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h05) return K_BNE;
        if (op == 6'h08) return K_ADDI;
        if (op == 6'h23) return K_LW;
        if (op == 6'h2B) return K_SW;
        return K_ILL;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic expect_cycle(input string tag, input logic [15:0] e);
        @(negedge clk);
        check(tag, got_ctrl, e);
        @(posedge clk);
        #1;
    endtask

    task automatic retire_one();
        model_cnt = model_cnt + 1'b1;
        exp_q.push_back(model_cnt);
        check("retired", retired, exp_q.pop_front());
        check("back_to_fetch", state_dbg, S_IF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", got_ctrl, 16'h0);
        check("rst_retired", retired, 0);
        check("rst_state", state_dbg, S_IF);
        model_cnt = '0;
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // zval < 0 randomises zero in EX; abort asserts rst during the first
    // memory wait cycle (needs mem_wait >= 1).
    task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input int if_wait,
                              input int mem_wait, input int zval, input bit abort,
                              output bit halted);
        int k;
        logic [15:0] e;
        logic z;
        k = classify(op, fn);
        halted = 1'b0;
        for (int i = 0; i < if_wait; i++) begin
            mem_ready = 1'b0;
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            zero   = 1'($urandom);
            expect_cycle("if_wait", mk(ALU_ADD, 0, 2'd1, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0));
        end
        mem_ready = 1'b1;
        expect_cycle("if_fetch", mk(ALU_ADD, 0, 2'd1, 1, 2'd0, 1, 1, 0, 0, 0, 0, 0));

        opcode = op;
        funct  = fn;
        mem_ready = 1'($urandom);
        zero = 1'($urandom);
        if (k == K_J) begin
            expect_cycle("id_jump", mk(ALU_ADD, 0, 2'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0));
            retire_one();
            return;
        end
        if (k == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
            expect_cycle("id_illegal", 16'h0);
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'($urandom);
                expect_cycle("halt", mk(ALU_ADD, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
                check("halt_state", state_dbg, S_HALT);
                check("halt_retired", retired, model_cnt);
            end
            halted = 1'b1;
`else
            expect_cycle("id_illegal", mk(ALU_ADD, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
            retire_one();
`endif
            return;
        end
        expect_cycle("id", 16'h0);

        z = (zval < 0) ? 1'($urandom) : zval[0];
        zero = z;
        mem_ready = 1'($urandom);
        case (k)
            K_ADD:   e = mk(ALU_ADD, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
            K_SUB:   e = mk(ALU_SUB, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
            K_BEQ:   e = mk(ALU_SUB, 1, 2'd0, z, 2'd1, 0, 0, 0, 0, 0, 0, 0);
            K_BNE:   e = mk(ALU_SUB, 1, 2'd0, !z, 2'd1, 0, 0, 0, 0, 0, 0, 0);
            default: e = mk(ALU_ADD, 1, 2'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        endcase
        expect_cycle("ex", e);
        if (k == K_BEQ || k == K_BNE) begin
            retire_one();
            return;
        end

        if (k == K_LW || k == K_SW) begin
            e = mk(ALU_ADD, 0, 2'd0, 0, 2'd0, 0, k == K_LW, k == K_SW, 0, 0, 0, 0);
            for (int i = 0; i < mem_wait; i++) begin
                mem_ready = 1'b0;
                if (abort) begin
                    @(negedge clk);
                    check("mem_before_rst", got_ctrl, e);
                    #2 rst = 1'b1;
                    #1;
                    check("rst_async_ctrl", got_ctrl, 16'h0);
                    check("rst_async_retired", retired, 0);
                    check("rst_async_state", state_dbg, S_IF);
                    model_cnt = '0;
                    exp_q.delete();
                    @(posedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    @(posedge clk);
                    #1;
                    return;
                end
                expect_cycle("mem_wait", e);
            end
            mem_ready = 1'b1;
            expect_cycle("mem_done", e);
            if (k == K_SW) begin
                retire_one();
                return;
            end
        end

        mem_ready = 1'($urandom);
        expect_cycle("wb", mk(ALU_ADD, 0, 2'd0, 0, 2'd0, 0, 0, 0, 1,
                              (k == K_ADD || k == K_SUB), (k == K_LW), 0));
        retire_one();
    endtask

    task automatic random_instr(input bit legal_only, output logic [5:0] op, output logic [5:0] fn);
        int r;
        logic [5:0] bad_op[3];
        logic [5:0] bad_fn[3];
        bad_op = '{6'h3F, 6'h01, 6'h10};
        bad_fn = '{6'h00, 6'h21, 6'h3F};
        r = legal_only ? $urandom_range(0, 15) : $urandom_range(0, 17);
        fn = 6'($urandom);
        case (r / 2)
            0: begin op = 6'h00; fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h22; end
            2: op = 6'h08;
            3: op = 6'h23;
            4: op = 6'h2B;
            5: op = 6'h04;
            6: op = 6'h05;
            7: op = 6'h02;
            default: begin
                if (r[0]) begin
                    op = 6'h00;
                    fn = bad_fn[$urandom_range(0, 2)];
                end else begin
                    op = bad_op[$urandom_range(0, 2)];
                end
            end
        endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit h;
        logic [5:0] op, fn;

        do_reset();

        // addi, no waits
        exec_instr(6'h08, 6'h00, 0, 0, -1, 0, h);
        // beq / bne with both Zero values
        exec_instr(6'h04, 6'h00, 0, 0, 1, 0, h);
        exec_instr(6'h04, 6'h00, 0, 0, 0, 0, h);
        exec_instr(6'h05, 6'h00, 0, 0, 1, 0, h);
        exec_instr(6'h05, 6'h00, 0, 0, 0, 0, h);
        // lw stalled twice in fetch and twice in memory
        exec_instr(6'h23, 6'h00, 2, 2, -1, 0, h);
        // unknown opcode
        exec_instr(6'h3F, 6'h00, 0, 0, -1, 0, h);
        if (h) do_reset();

        // randomised instruction stream with random stalls
        for (int n = 0; n < 150; n++) begin
            random_instr(1'b0, op, fn);
            exec_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), -1, 0, h);
            if (h) do_reset();
        end

        // reset while sw is waiting in memory
        exec_instr(6'h02, 6'h00, 0, 0, -1, 0, h);
        exec_instr(6'h2B, 6'h00, 1, 2, -1, 1, h);
        exec_instr(6'h08, 6'h00, 0, 0, -1, 0, h);

        // counter wrap: bring retired to all-ones, then retire an add
        do_reset();
        for (int n = 0; n < (1 << CNTW) - 1; n++) begin
            random_instr(1'b1, op, fn);
            exec_instr(op, fn, $urandom_range(0, 1), $urandom_range(0, 1), -1, 0, h);
        end
        check("pre_wrap", retired, {CNTW{1'b1}});
        exec_instr(6'h00, 6'h20, 0, 0, -1, 0, h);
        check("wrap_to_zero", retired, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
